// File: rtl/chs_pkg.sv
// Shared constants for the cool/heat sequencer: FSM encodings, chs_conf
// field positions, mode values and parameter defaults.
package chs_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RAMP  = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_DWELL = 2'd3;

   localparam logic [1:0] AUTO_OFF  = 2'd0;
   localparam logic [1:0] AUTO_COOL = 2'd1;
   localparam logic [1:0] AUTO_HEAT = 2'd2;

   localparam int unsigned CONF_EN        = 5;
   localparam int unsigned CONF_MODE      = 4;
   localparam int unsigned CONF_POWER_MSB = 3;
   localparam int unsigned CONF_POWER_LSB = 0;

   localparam logic MODE_COOL = 1'b1;
   localparam logic MODE_HEAT = 1'b0;

   localparam int unsigned RAMP_DIV_DEF  = 16;
   localparam int unsigned DWELL_CYC_DEF = 64;

   // |a-b| clamped to the 4-bit power range
   function automatic logic [3:0] sat_power(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] diff;
      diff = (a >= b) ? (a - b) : (b - a);
      return (diff > 8'd15) ? 4'hF : diff[3:0];
   endfunction

endpackage

// File: rtl/chs_sequencer_if.sv
// Manual-command valid/ready channel into the sequencer.
interface chs_sequencer_if;

   logic       man_valid;
   logic [5:0] man_cmd;
   logic       man_ready;

   modport master (output man_valid, output man_cmd, input man_ready);
   modport slave  (input man_valid, input man_cmd, output man_ready);

endinterface

// File: rtl/chs_auto_target.sv
// Thermostat hysteresis: registered off/cool/heat decision plus the
// saturated power request that goes with it.
module chs_auto_target
   import chs_pkg::*;
(
   input  logic       clk,
   input  logic       arst,
   input  logic [7:0] temp,
   input  logic [7:0] setpoint,
   input  logic [3:0] hyst,
   output logic       mode,
   output logic [3:0] power
);

   logic [1:0] state;
   logic [1:0] state_d;
   logic [8:0] t9;
   logic [8:0] s9;
   logic [8:0] h9;

   assign t9 = {1'b0, temp};
   assign s9 = {1'b0, setpoint};
   assign h9 = {5'b0, hyst};

   always_comb begin
      state_d = state;
      case (state)
         AUTO_OFF: begin
            if (t9 > s9 + h9)      state_d = AUTO_COOL;
            else if (t9 + h9 < s9) state_d = AUTO_HEAT;
         end
         AUTO_COOL: if (!(t9 > s9)) state_d = AUTO_OFF;
         AUTO_HEAT: if (!(t9 < s9)) state_d = AUTO_OFF;
         default:   state_d = AUTO_OFF;
      endcase
   end

   // Power is registered alongside the decision so both move together.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state <= AUTO_OFF;
         mode  <= MODE_HEAT;
         power <= '0;
      end else begin
         state <= state_d;
         mode  <= (state_d == AUTO_COOL) ? MODE_COOL : MODE_HEAT;
         power <= (state_d == AUTO_OFF) ? 4'h0 : sat_power(temp, setpoint);
      end
   end

endmodule

// File: rtl/chs_sequencer.sv
// Cool/heat power sequencer: ramps power one step at a time, and forces an
// off-time dwell before any mode reversal or shutdown.
module chs_sequencer
   import chs_pkg::*;
#(
   parameter int unsigned RAMP_DIV  = RAMP_DIV_DEF,
   parameter int unsigned DWELL_CYC = DWELL_CYC_DEF
) (
   input  logic           clk,
   input  logic           arst,
   input  logic [7:0]     temp,
   input  logic [7:0]     setpoint,
   input  logic [3:0]     hyst,
   chs_sequencer_if.slave man,
   output logic [7:0]     chs_conf,
   output logic           busy
);

   localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int unsigned DW_W  = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(RAMP_DIV - 1);
   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYC - 1);

   logic [1:0]       state;
   logic             cur_mode;
   logic [3:0]       cur_power;
   logic [DIV_W-1:0] div_cnt;
   logic [DW_W-1:0]  dwell_cnt;
   logic             ovr;
   logic             man_mode;
   logic [3:0]       man_power;
   logic             auto_mode;
   logic [3:0]       auto_power;
   logic             tgt_mode;
   logic [3:0]       tgt_power;
   logic [3:0]       desired;
   logic [3:0]       step_power;
   logic             en;
   logic [7:0]       conf_d;

   chs_auto_target u_auto (
      .clk      (clk),
      .arst     (arst),
      .temp     (temp),
      .setpoint (setpoint),
      .hyst     (hyst),
      .mode     (auto_mode),
      .power    (auto_power)
   );

   assign man.man_ready = (state != ST_DWELL);
   assign busy          = (state != ST_IDLE);
   assign en            = (state == ST_RAMP) || (state == ST_HOLD);

   always_comb begin
      tgt_mode   = ovr ? man_mode  : auto_mode;
      tgt_power  = ovr ? man_power : auto_power;
      // A target in the other mode pulls power to zero first.
      desired    = (tgt_mode == cur_mode) ? tgt_power : 4'h0;
      step_power = cur_power;
      if (cur_power < desired)      step_power = cur_power + 4'd1;
      else if (cur_power > desired) step_power = cur_power - 4'd1;
   end

   always_comb begin
      conf_d = '0;
      if (en) begin
         conf_d[CONF_EN]                           = 1'b1;
         conf_d[CONF_MODE]                         = cur_mode;
         conf_d[CONF_POWER_MSB:CONF_POWER_LSB]     = cur_power;
      end
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         ovr       <= 1'b0;
         man_mode  <= MODE_HEAT;
         man_power <= '0;
      end else if (man.man_valid && man.man_ready) begin
         ovr <= man.man_cmd[5];
         if (man.man_cmd[5]) begin
            man_mode  <= man.man_cmd[4];
            man_power <= man.man_cmd[3:0];
         end
      end
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state     <= ST_IDLE;
         cur_mode  <= MODE_HEAT;
         cur_power <= '0;
         div_cnt   <= '0;
         dwell_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (tgt_power != 4'h0) begin
                  cur_mode <= tgt_mode;
                  div_cnt  <= '0;
                  state    <= ST_RAMP;
               end
            end
            ST_RAMP: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt   <= '0;
                  dwell_cnt <= '0;
                  cur_power <= step_power;
                  if (step_power == desired)
                     state <= (desired == 4'h0) ? ST_DWELL : ST_HOLD;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            ST_HOLD: begin
               if ({tgt_mode, tgt_power} != {cur_mode, cur_power}) begin
                  div_cnt <= '0;
                  state   <= ST_RAMP;
               end
            end
            default: begin
               if (dwell_cnt == DWELL_LAST) begin
                  dwell_cnt <= '0;
                  if (tgt_power != 4'h0) begin
                     cur_mode <= tgt_mode;
                     div_cnt  <= '0;
                     state    <= ST_RAMP;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  dwell_cnt <= dwell_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) chs_conf <= 8'h00;
      else       chs_conf <= conf_d;
   end

endmodule

// File: tb/tb_chs_sequencer.sv
// Directed scenarios plus randomized temperature/command traffic, all
// checked cycle by cycle against a behavioural model of the sequencer.
module tb_chs_sequencer;

   localparam int unsigned RD = 4;
   localparam int unsigned DC = 8;

   logic       clk = 1'b0;
   logic       arst;
   logic [7:0] temp;
   logic [7:0] setpoint;
   logic [3:0] hyst;
   logic [7:0] chs_conf;
   logic       busy;

   chs_sequencer_if man_bus ();

   chs_sequencer #(.RAMP_DIV(RD), .DWELL_CYC(DC)) dut (
      .clk      (clk),
      .arst     (arst),
      .temp     (temp),
      .setpoint (setpoint),
      .hyst     (hyst),
      .man      (man_bus),
      .chs_conf (chs_conf),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // model: thermostat decision (0 off, 1 cool, 2 heat) and its request
   int m_auto, m_amode, m_apower;
   int m_ovr, m_omode, m_opower;
   // model: phase 0 idle, 1 ramping, 2 holding, 3 dwelling
   int m_phase, m_mode, m_power, m_timer;
   logic [7:0] m_conf;

   task automatic model_reset();
      m_auto = 0; m_amode = 0; m_apower = 0;
      m_ovr = 0; m_omode = 0; m_opower = 0;
      m_phase = 0; m_mode = 0; m_power = 0; m_timer = 0;
      m_conf = 8'h00;
   endtask

   task automatic model_edge();
      int t, s, h, nxt, tm, tp, want, d;
      logic [5:0] cmd;
      t = int'(temp); s = int'(setpoint); h = int'(hyst);
      cmd = man_bus.man_cmd;
      tm = (m_ovr != 0) ? m_omode : m_amode;
      tp = (m_ovr != 0) ? m_opower : m_apower;
      m_conf = (m_phase == 1 || m_phase == 2) ? 8'(32 + 16 * m_mode + m_power) : 8'h00;
      if (man_bus.man_valid === 1'b1 && m_phase != 3) begin
         m_ovr = int'(cmd[5]);
         if (cmd[5]) begin
            m_omode  = int'(cmd[4]);
            m_opower = int'(cmd[3:0]);
         end
      end
      case (m_auto)
         0:       nxt = (t > s + h) ? 1 : ((t + h < s) ? 2 : 0);
         1:       nxt = (t > s) ? 1 : 0;
         default: nxt = (t < s) ? 2 : 0;
      endcase
      d = (t > s) ? t - s : s - t;
      m_auto   = nxt;
      m_amode  = (nxt == 1) ? 1 : 0;
      m_apower = (nxt == 0) ? 0 : ((d > 15) ? 15 : d);
      case (m_phase)
         0: if (tp > 0) begin m_mode = tm; m_phase = 1; m_timer = 0; end
         1: begin
            m_timer++;
            if (m_timer == RD) begin
               m_timer = 0;
               want = (tm == m_mode) ? tp : 0;
               if (m_power < want) m_power++;
               else if (m_power > want) m_power--;
               if (m_power == want) m_phase = (want == 0) ? 3 : 2;
            end
         end
         2: if (tm != m_mode || tp != m_power) begin m_phase = 1; m_timer = 0; end
         default: begin
            m_timer++;
            if (m_timer == DC) begin
               m_timer = 0;
               if (tp > 0) begin m_mode = tm; m_phase = 1; end
               else m_phase = 0;
            end
         end
      endcase
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      chk("conf", chs_conf, m_conf);
      chk("busy", {7'd0, busy}, 8'(m_phase != 0));
      chk("ready", {7'd0, man_bus.man_ready}, 8'(m_phase != 3));
   endtask

   task automatic do_reset();
      #2 arst = 1'b0;
      #1;
      chk("rst_conf", chs_conf, 8'h00);
      chk("rst_busy", {7'd0, busy}, 8'h00);
      chk("rst_ready", {7'd0, man_bus.man_ready}, 8'h01);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      arst = 1'b1;
   endtask

   task automatic wait_for(input string tag, input logic [7:0] val, input int budget, output int cyc);
      cyc = 0;
      while (chs_conf !== val && cyc < budget) begin
         tick();
         cyc++;
      end
      chk(tag, chs_conf, val);
   endtask

   task automatic dwell_len(input int budget, output int n);
      int k;
      k = 0;
      n = 0;
      while (man_bus.man_ready === 1'b1 && k < budget) begin tick(); k++; end
      while (man_bus.man_ready === 1'b0 && k < budget) begin tick(); k++; n++; end
   endtask

   task automatic send_cmd(input logic [5:0] cmd);
      man_bus.man_valid = 1'b1;
      man_bus.man_cmd   = cmd;
      tick();
      man_bus.man_valid = 1'b0;
   endtask

   initial begin
      int c, n, t, lowseen;
      logic [7:0] v;
      arst = 1'b0;
      temp = 8'd100; setpoint = 8'd100; hyst = 4'd2;
      man_bus.man_valid = 1'b0;
      man_bus.man_cmd   = 6'h00;
      model_reset();
      #1;
      chk("rst0_conf", chs_conf, 8'h00);
      chk("rst0_busy", {7'd0, busy}, 8'h00);
      chk("rst0_ready", {7'd0, man_bus.man_ready}, 8'h01);
      @(negedge clk);
      arst = 1'b1;

      // inside the band from off: nothing starts
      temp = 8'd101;
      repeat (20) tick();
      chk("band_idle", chs_conf, 8'h00);

      // auto cool ramps one step per RD cycles to 5
      temp = 8'd105;
      wait_for("cool_31", 8'h31, 40, c);
      for (int i = 2; i <= 5; i++) begin
         v = 8'h30 + 8'(i);
         wait_for("cool_step", v, 2 * RD, c);
         chk("cool_gap", 8'(c), 8'(RD));
      end
      repeat (12) tick();
      chk("cool_hold", chs_conf, 8'h35);

      // still above setpoint keeps cooling at low power
      temp = 8'd101;
      wait_for("band_cool", 8'h31, 40, c);
      repeat (12) tick();
      chk("band_cool_hold", chs_conf, 8'h31);

      // at setpoint: ramp to off, dwell, idle
      temp = 8'd100;
      dwell_len(60, n);
      chk("off_dwell_len", 8'(n), 8'(DC));
      chk("off_idle_busy", {7'd0, busy}, 8'h00);
      chk("off_idle_conf", chs_conf, 8'h00);

      // manual heat 3 while cooling at 5: down, dwell, up in heat
      temp = 8'd105;
      wait_for("rev_pre", 8'h35, 80, c);
      send_cmd(6'h23);
      dwell_len(100, n);
      chk("rev_dwell_len", 8'(n), 8'(DC));
      wait_for("rev_21", 8'h21, 2 * RD + 2, c);
      wait_for("rev_22", 8'h22, 2 * RD, c);
      chk("rev_gap", 8'(c), 8'(RD));
      wait_for("rev_23", 8'h23, 2 * RD, c);
      repeat (12) tick();
      chk("rev_hold", chs_conf, 8'h23);

      // dropping override hands control back to auto cooling
      send_cmd(6'h00);
      wait_for("auto_back", 8'h35, 150, c);

      // large error saturates power
      temp = 8'd255; setpoint = 8'd0;
      wait_for("sat", 8'h3F, 120, c);
      repeat (20) tick();
      chk("sat_hold", chs_conf, 8'h3F);

      // reset mid-ramp: restart from scratch, no dwell owed
      do_reset();
      temp = 8'd105; setpoint = 8'd100; hyst = 4'd2;
      wait_for("mid_33", 8'h33, 60, c);
      do_reset();
      lowseen = 0;
      c = 0;
      while (chs_conf !== 8'h31 && c < 20) begin
         tick();
         c++;
         if (man_bus.man_ready !== 1'b1) lowseen++;
      end
      chk("mid_restart", chs_conf, 8'h31);
      chk("mid_no_dwell", 8'(lowseen), 8'h00);

      // randomized traffic around the setpoint
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) setpoint = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 14) == 0) begin
            t = int'(setpoint) + int'($urandom_range(0, 40)) - 20;
            if (t < 0) t = 0;
            if (t > 255) t = 255;
            temp = 8'(t);
         end
         if ($urandom_range(0, 99) == 0) hyst = 4'($urandom_range(0, 15));
         man_bus.man_valid = ($urandom_range(0, 59) == 0);
         man_bus.man_cmd   = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 799) == 0) do_reset();
         tick();
      end
      man_bus.man_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
